antilog_dec: RTL and testbench

ANTILOG_DEC -- requirements
Module: antilog_dec

---
 rtl/mitchell_pkg.sv | 9 +
 rtl/antilog_dec_if.sv | 25 ++
 rtl/therm_dec.sv | 11 +
 rtl/antilog_dec.sv | 69 ++++++
 tb/tb_antilog_dec.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/mitchell_pkg.sv
// mitchell_pkg: shared Mitchell log/antilog widths and constants for encoder and decoder sides.
package mitchell_pkg;
  localparam int W = 8;
  localparam int FW = W - 1;
  localparam int KW = 4;
  localparam int OW = 2 * W;
  localparam int K_MAX = 2 * W - 2;
  localparam logic [OW-1:0] SAT = '1;
endpackage

// File: rtl/antilog_dec_if.sv
// antilog_dec_if: log-domain input and linear-domain output handshakes of the antilog decoder.
interface antilog_dec_if #(
  parameter int W = mitchell_pkg::W,
  parameter int KW = mitchell_pkg::KW,
  parameter int OW = mitchell_pkg::OW
);
  logic in_valid;
  logic in_ready;
  logic in_zero;
  logic [KW-1:0] in_k;
  logic [W-2:0] in_frac;
  logic out_valid;
  logic out_ready;
  logic [OW-1:0] out_value;
  logic [OW-1:0] out_therm;
  logic out_ovf;
  modport slave (
    input in_valid, in_zero, in_k, in_frac, out_ready,
    output in_ready, out_valid, out_value, out_therm, out_ovf
  );
  modport master (
    output in_valid, in_zero, in_k, in_frac, out_ready,
    input in_ready, out_valid, out_value, out_therm, out_ovf
  );
endinterface

// File: rtl/therm_dec.sv
// therm_dec: index to thermometer mask with bits 0..k set; inverse of the leading-one encoder.
module therm_dec #(
  parameter int KW = mitchell_pkg::KW,
  parameter int OW = mitchell_pkg::OW
) (
  input  logic [KW-1:0] i_k,
  output logic [OW-1:0] o_mask
);
  // The extra <<1 makes bit k itself part of the mask; k = OW-1 naturally yields all ones.
  assign o_mask = ~(({OW{1'b1}} << i_k) << 1);
endmodule

// File: rtl/antilog_dec.sv
// antilog_dec: two-stage Mitchell antilog (S1 decode, S2 shift) with valid/ready handshakes.
module antilog_dec #(
  parameter int W = mitchell_pkg::W,
  parameter int KW = mitchell_pkg::KW,
  parameter int OW = mitchell_pkg::OW
) (
  input logic clk,
  input logic rst_n,
  antilog_dec_if.slave bus
);
  import mitchell_pkg::*;
  localparam int IW = W + K_MAX;
  localparam logic [KW-1:0] KM = KW'(K_MAX);
  logic r_s1_v, r_s1_zero, r_s1_ovf;
  logic [KW-1:0] r_s1_k;
  logic [W-2:0] r_s1_frac;
  logic [OW-1:0] r_s1_therm;
  logic r_s2_v, r_s2_ovf;
  logic [OW-1:0] r_s2_value, r_s2_therm;
  logic w_s2_ld, w_s1_ld, w_ovf;
  logic [OW-1:0] w_mask, w_value;
  logic [IW-1:0] w_shift;
  assign w_s2_ld = !r_s2_v || bus.out_ready;
  assign bus.in_ready = !r_s1_v || w_s2_ld;
  assign w_s1_ld = bus.in_valid && bus.in_ready;
  assign w_ovf = !bus.in_zero && (bus.in_k > KM);
  therm_dec #(.KW(KW), .OW(OW)) u_therm (.i_k(bus.in_k), .o_mask(w_mask));
  // Full-width shift so no mantissa bit is lost before dropping the FW fraction bits.
  assign w_shift = {{(IW-W){1'b0}}, 1'b1, r_s1_frac} << r_s1_k;
  assign w_value = OW'(w_shift >> (W - 1));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_v <= 1'b0;
      r_s1_zero <= 1'b0;
      r_s1_ovf <= 1'b0;
      r_s1_k <= '0;
      r_s1_frac <= '0;
      r_s1_therm <= '0;
    end else begin
      if (bus.in_ready) r_s1_v <= bus.in_valid;
      if (w_s1_ld) begin
        r_s1_zero <= bus.in_zero;
        r_s1_ovf <= w_ovf;
        r_s1_k <= bus.in_k;
        r_s1_frac <= bus.in_frac;
        r_s1_therm <= bus.in_zero ? '0 : w_ovf ? SAT : w_mask;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_v <= 1'b0;
      r_s2_ovf <= 1'b0;
      r_s2_value <= '0;
      r_s2_therm <= '0;
    end else if (w_s2_ld) begin
      r_s2_v <= r_s1_v;
      if (r_s1_v) begin
        r_s2_ovf <= r_s1_ovf;
        r_s2_value <= r_s1_zero ? '0 : r_s1_ovf ? SAT : w_value;
        r_s2_therm <= r_s1_therm;
      end
    end
  end
  assign bus.out_valid = r_s2_v;
  assign bus.out_value = r_s2_value;
  assign bus.out_therm = r_s2_therm;
  assign bus.out_ovf = r_s2_ovf;
endmodule

// File: tb/tb_antilog_dec.sv
// tb_antilog_dec: scoreboard bench for antilog_dec; expected words queued on input transfer, compared at output.
module tb_antilog_dec;
  typedef struct packed {
    logic [15:0] v;
    logic [15:0] t;
    logic o;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  antilog_dec_if bus ();
  antilog_dec dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  exp_t sb[$];
  int n_chk = 0;
  int n_fail = 0;
  int n_in = 0;
  int n_out = 0;
  int acc;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic exp_t model(input logic z, input logic [3:0] k, input logic [6:0] f);
    exp_t e;
    int v;
    if (z) e = '0;
    else if (k > 4'd14) e = {16'hFFFF, 16'hFFFF, 1'b1};
    else begin
      v = ((128 + int'(f)) * (1 << k)) / 128;
      e.v = 16'(v);
      e.t = 16'((1 << (int'(k) + 1)) - 1);
      e.o = 1'b0;
    end
    return e;
  endfunction
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.out_valid && sb.size() > 0) begin
        check("value", bus.out_value, sb[0].v);
        check("therm", bus.out_therm, sb[0].t);
        check("ovf", bus.out_ovf, sb[0].o);
        if (bus.out_ready) begin
          void'(sb.pop_front());
          n_out++;
        end
      end else if (sb.size() == 0) check("spurious", bus.out_valid, 0);
      if (bus.in_valid && bus.in_ready) begin
        sb.push_back(model(bus.in_zero, bus.in_k, bus.in_frac));
        n_in++;
      end
    end
  end
  task automatic put(input logic v, input logic z, input logic [3:0] k, input logic [6:0] f);
    bus.in_valid = v;
    bus.in_zero = z;
    bus.in_k = k;
    bus.in_frac = f;
  endtask
  task automatic send(input logic z, input logic [3:0] k, input logic [6:0] f);
    bit ok = 1'b0;
    put(1'b1, z, k, f);
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      ok = bus.in_ready;
    end
    check("send_acc", {31'b0, ok}, 1);
    @(posedge clk);
    #1 put(1'b0, 1'b0, 4'd0, 7'd0);
  endtask
  task automatic drain();
    for (int n = 0; n < 200 && sb.size() != 0; n++) @(posedge clk);
    #1 check("drain", sb.size(), 0);
  endtask
  task automatic feed_k(input int cycles, input int lim);
    for (int c = 0; c < cycles && acc < lim; c++) begin
      put(1'b1, 1'b0, 4'(acc + 1), 7'd0);
      @(negedge clk);
      if (bus.in_ready) acc++;
      @(posedge clk);
      #1;
    end
  endtask
  initial begin
    #1000000 $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    put(1'b0, 1'b0, 4'd0, 7'd0);
    bus.out_ready = 1'b1;
    #1 rst_n = 1'b0;
    #7;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_value", bus.out_value, 0);
    check("rst_out_therm", bus.out_therm, 0);
    check("rst_out_ovf", bus.out_ovf, 0);
    check("rst_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(1'b0, 4'd0, 7'h00);
    @(negedge clk) check("lat1", bus.out_valid, 0);
    @(negedge clk) check("lat2", bus.out_valid, 1);
    @(posedge clk);
    #1;
    send(1'b0, 4'd7, 7'h40);
    send(1'b0, 4'd14, 7'h7F);
    send(1'b0, 4'd15, 7'h2A);
    send(1'b1, 4'd15, 7'h7F);
    send(1'b1, 4'd3, 7'h11);
    send(1'b0, 4'd1, 7'h00);
    drain();
    bus.out_ready = 1'b0;
    acc = 0;
    feed_k(5, 4);
    check("stall_acc", acc, 2);
    check("stall_rdy", bus.in_ready, 0);
    check("stall_val", bus.out_value, 16'h0002);
    bus.out_ready = 1'b1;
    feed_k(20, 4);
    put(1'b0, 1'b0, 4'd0, 7'd0);
    check("stall_all", acc, 4);
    drain();
    acc = 0;
    for (int c = 0; c < 60000 && acc < 10000; c++) begin
      put($urandom_range(0, 9) < 8, $urandom_range(0, 19) == 0, 4'($urandom_range(0, 15)), 7'($urandom));
      bus.out_ready = $urandom_range(0, 9) < 8;
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) acc++;
      @(posedge clk);
      #1;
    end
    put(1'b0, 1'b0, 4'd0, 7'd0);
    bus.out_ready = 1'b1;
    check("rand_words", acc, 10000);
    drain();
    check("in_out", n_out, n_in);
    bus.out_ready = 1'b0;
    send(1'b0, 4'd3, 7'h00);
    send(1'b0, 4'd5, 7'h00);
    check("full_rdy", bus.in_ready, 0);
    check("full_ov", bus.out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", bus.out_valid, 0);
    check("arst_in_ready", bus.in_ready, 1);
    check("arst_out_value", bus.out_value, 0);
    sb.delete();
    @(posedge clk);
    #3 rst_n = 1'b1;
    bus.out_ready = 1'b1;
    put(1'b1, 1'b0, 4'd6, 7'h00);
    @(negedge clk) check("post_rst_rdy", bus.in_ready, 1);
    @(posedge clk);
    #1 put(1'b0, 1'b0, 4'd0, 7'd0);
    drain();
    repeat (4) @(posedge clk);
    #1 check("final_idle", bus.out_valid, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
